// File: rtl/gmii_pkg.sv
// rtl/gmii_pkg.sv - shared state type, framing constants and CRC-32 byte step
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_HDR  = 3'd3,
        ST_PAY  = 3'd4,
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } gmii_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [10:0] PREAMBLE_LEN  = 11'd7;
    localparam logic [10:0] HDR_LEN       = 11'd14;
    localparam logic [10:0] FCS_LEN       = 11'd4;
    localparam logic [10:0] MIN_PAYLOAD   = 11'd46;
    localparam logic [10:0] MAX_PAYLOAD   = 11'd1500;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Ethernet shifts LSB first, so the register runs in reflected form
    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

    function automatic logic [31:0] crc32_byte_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - registered byte-wide Ethernet CRC-32 with clear and enable
module crc32_d8
    import gmii_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc_out <= CRC_INIT;
        end else if (clear) begin
            crc_out <= CRC_INIT;
        end else if (en) begin
            crc_out <= crc32_byte_next(crc_out, data);
        end
    end

endmodule

// File: rtl/gmii_frame_gen.sv
// rtl/gmii_frame_gen.sv - GMII test-frame source: preamble, header, counting payload, FCS, IFG
module gmii_frame_gen
    import gmii_pkg::*;
#(
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MIN_IFG   = 12
) (
    input  logic        userclk2,
    input  logic        sys_reset_n,
    input  logic        enable,
    input  logic        link_up,
    input  logic [10:0] frame_len,
    input  logic [7:0]  ifg_len,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [31:0] frame_cnt,
    output logic        busy
);

    localparam logic [13:0][7:0] HDR_BYTES = {48'hFFFF_FFFF_FFFF, SRC_MAC, ETHERTYPE};
    localparam logic [7:0]       MIN_IFG_B = 8'(MIN_IFG);

    gmii_state_t      state;
    gmii_state_t      state_n;
    logic [10:0]      cnt;
    logic [10:0]      cnt_n;
    logic [10:0]      lat_len;
    logic [10:0]      lat_len_n;
    logic [7:0]       lat_ifg;
    logic [7:0]       lat_ifg_n;
    logic [7:0]       seq;
    logic             frame_done;
    logic             start;
    logic [10:0]      len_clamped;
    logic [7:0]       ifg_clamped;
    logic [7:0]       txd_n;
    logic             tx_en_n;
    logic             crc_clear;
    logic             crc_en;
    logic [31:0]      crc;
    logic [3:0][7:0]  fcs_bytes;

    assign start       = enable && link_up;
    assign len_clamped = (frame_len < MIN_PAYLOAD) ? MIN_PAYLOAD :
                         (frame_len > MAX_PAYLOAD) ? MAX_PAYLOAD : frame_len;
    assign ifg_clamped = (ifg_len < MIN_IFG_B) ? MIN_IFG_B : ifg_len;

    // state/cnt name the byte currently on the wire; *_n name the byte loaded at the next edge
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 11'd1;
        lat_len_n  = lat_len;
        lat_ifg_n  = lat_ifg;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n   = ST_PRE;
                    lat_len_n = len_clamped;
                    lat_ifg_n = ifg_clamped;
                end
            end
            ST_PRE: begin
                if (cnt == PREAMBLE_LEN - 11'd1) begin
                    state_n = ST_SFD;
                    cnt_n   = '0;
                end
            end
            ST_SFD: begin
                state_n = ST_HDR;
                cnt_n   = '0;
            end
            ST_HDR: begin
                if (cnt == HDR_LEN - 11'd1) begin
                    state_n = ST_PAY;
                    cnt_n   = '0;
                end
            end
            ST_PAY: begin
                if (cnt == lat_len - 11'd1) begin
                    state_n = ST_FCS;
                    cnt_n   = '0;
                end
            end
            ST_FCS: begin
                if (cnt == FCS_LEN - 11'd1) begin
                    state_n = ST_IFG;
                    cnt_n   = '0;
                end
            end
            ST_IFG: begin
                if (cnt == {3'b000, lat_ifg} - 11'd1) begin
                    frame_done = 1'b1;
                    cnt_n      = '0;
                    if (start) begin
                        state_n   = ST_PRE;
                        lat_len_n = len_clamped;
                        lat_ifg_n = ifg_clamped;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // crc already holds DA..last payload byte by the time the first FCS byte is selected
    assign fcs_bytes = ~crc;

    always_comb begin
        case (state_n)
            ST_PRE:  txd_n = PREAMBLE_BYTE;
            ST_SFD:  txd_n = SFD_BYTE;
            ST_HDR:  txd_n = HDR_BYTES[4'd13 - cnt_n[3:0]];
            ST_PAY:  txd_n = seq + cnt_n[7:0];
            ST_FCS:  txd_n = fcs_bytes[cnt_n[1:0]];
            default: txd_n = 8'h00;
        endcase
    end

    assign tx_en_n   = state_n inside {ST_PRE, ST_SFD, ST_HDR, ST_PAY, ST_FCS};
    assign crc_clear = (state_n == ST_SFD);
    assign crc_en    = (state_n == ST_HDR) || (state_n == ST_PAY);

    crc32_d8 u_crc (
        .clk     (userclk2),
        .resetn  (sys_reset_n),
        .clear   (crc_clear),
        .en      (crc_en),
        .data    (txd_n),
        .crc_out (crc)
    );

    always_ff @(posedge userclk2) begin
        if (!sys_reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_len    <= MIN_PAYLOAD;
            lat_ifg    <= MIN_IFG_B;
            seq        <= 8'h00;
            frame_cnt  <= 32'h0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lat_len    <= lat_len_n;
            lat_ifg    <= lat_ifg_n;
            gmii_txd   <= txd_n;
            gmii_tx_en <= tx_en_n;
            gmii_tx_er <= 1'b0;
            busy       <= (state_n != ST_IDLE);
            if (frame_done) begin
                frame_cnt <= frame_cnt + 32'd1;
                seq       <= seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_frame_gen.sv
// tb/tb_gmii_frame_gen.sv - scoreboard bench for gmii_frame_gen
module tb_gmii_frame_gen;

    logic        userclk2 = 1'b0;
    logic        sys_reset_n;
    logic        enable;
    logic        link_up;
    logic [10:0] frame_len;
    logic [7:0]  ifg_len;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic [31:0] frame_cnt;
    logic        busy;

    typedef struct {
        int         len;
        logic [7:0] seq;
        int         gap;
        bit         trunc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mon_fr[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  m_seq = 8'h00;
    logic [31:0] m_cnt = 32'h0;

    gmii_frame_gen dut (
        .userclk2    (userclk2),
        .sys_reset_n (sys_reset_n),
        .enable      (enable),
        .link_up     (link_up),
        .frame_len   (frame_len),
        .ifg_len     (ifg_len),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #4 userclk2 = ~userclk2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // bit-serial reflected CRC-32, one input bit at a time
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic check_frame(input int gap_seen);
        exp_t        e;
        logic [7:0]  ex[$];
        logic [111:0] hw;
        logic [31:0] c;
        logic [31:0] fcs_exp;
        logic [31:0] fcs_rx;
        int          nbad;
        int          first;
        int          n;
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'(mon_fr.size()), 64'd0);
            return;
        end
        e = exp_q.pop_front();
        if (e.trunc) begin
            check("trunc_len", 64'(mon_fr.size() < 26 + e.len), 64'd1);
            return;
        end
        check("tx_en_len", 64'(mon_fr.size()), 64'(26 + e.len));
        if (e.gap >= 0) check("ifg_gap", 64'(gap_seen), 64'(e.gap));
        hw = 112'hFFFF_FFFF_FFFF_0200_0000_0001_88B5;
        for (int i = 0; i < 7; i++) ex.push_back(8'h55);
        ex.push_back(8'hD5);
        for (int k = 0; k < 14; k++) ex.push_back(hw[111-8*k -: 8]);
        for (int i = 0; i < e.len; i++) ex.push_back(e.seq + 8'(i));
        c = 32'hFFFFFFFF;
        for (int i = 8; i < ex.size(); i++) c = crc_step(c, ex[i]);
        fcs_exp = ~c;
        for (int k = 0; k < 4; k++) ex.push_back(fcs_exp[8*k +: 8]);
        nbad = 0;
        first = -1;
        n = (mon_fr.size() < ex.size()) ? mon_fr.size() : ex.size();
        for (int i = 0; i < n; i++) begin
            if (mon_fr[i] !== ex[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("frame_bytes(first_bad_at=%0d)", first), 64'(nbad), 64'd0);
        if (mon_fr.size() == ex.size()) begin
            for (int k = 0; k < 4; k++) fcs_rx[8*k +: 8] = mon_fr[22 + e.len + k];
            check("fcs", 64'(fcs_rx), 64'(fcs_exp));
            c = 32'hFFFFFFFF;
            for (int i = 8; i < mon_fr.size(); i++) c = crc_step(c, mon_fr[i]);
            check("crc_residue", 64'(bitrev(c)), 64'h0000_0000_C704_DD7B);
        end
    endtask

    initial begin : monitor
        bit in_fr;
        int gap;
        int gap_seen;
        in_fr = 1'b0;
        gap = 0;
        gap_seen = 0;
        forever begin
            @(negedge userclk2);
            if (gmii_tx_en === 1'b1) begin
                if (!in_fr) begin
                    in_fr = 1'b1;
                    gap_seen = gap;
                    mon_fr.delete();
                end
                mon_fr.push_back(gmii_txd);
            end else begin
                if (in_fr) begin
                    in_fr = 1'b0;
                    check_frame(gap_seen);
                    gap = 0;
                end
                gap++;
            end
        end
    end

    task automatic wait_txen(input logic level, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge userclk2);
            if (gmii_tx_en === level) return;
        end
        timeout(name);
    endtask

    task automatic wait_frame_cnt(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge userclk2);
            if (frame_cnt === m_cnt) return;
        end
        timeout("frame_cnt_wait");
    endtask

    task automatic run_frames(input int n, input logic [10:0] flen, input logic [7:0] ilen,
                              input int elen, input int egap, input int drop_at, input int link_hold);
        exp_t e;
        int   highs;
        frame_len = flen;
        ifg_len   = ilen;
        for (int i = 0; i < n; i++) begin
            e.len   = elen;
            e.seq   = m_seq;
            e.gap   = (i == 0) ? -1 : egap;
            e.trunc = 1'b0;
            exp_q.push_back(e);
            m_seq = m_seq + 8'd1;
        end
        m_cnt = m_cnt + 32'(n);
        enable = 1'b1;
        if (link_hold > 0) begin
            link_up = 1'b0;
            highs = 0;
            repeat (link_hold) begin
                @(negedge userclk2);
                if (gmii_tx_en !== 1'b0) highs++;
            end
            check("no_link_idle", 64'(highs), 64'd0);
        end
        link_up = 1'b1;
        @(negedge userclk2);
        check("start_latency", 64'(gmii_tx_en), 64'd1);
        check("busy_frame", 64'(busy), 64'd1);
        if (gmii_tx_en !== 1'b1) wait_txen(1'b1, 100, "start_txen");
        for (int i = 1; i < n; i++) begin
            wait_txen(1'b0, 2000, "frame_end");
            wait_txen(1'b1, 2000, "frame_start");
        end
        repeat (drop_at) @(negedge userclk2);
        enable = 1'b0;
        wait_frame_cnt(4000);
        check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
        check("busy_idle", 64'(busy), 64'd0);
        highs = 0;
        repeat (40) begin
            @(negedge userclk2);
            if (gmii_tx_en !== 1'b0) highs++;
        end
        check("stay_idle", 64'(highs), 64'd0);
    endtask

    initial begin : stimulus
        exp_t e;
        sys_reset_n = 1'b0;
        enable      = 1'b0;
        link_up     = 1'b0;
        frame_len   = 11'd46;
        ifg_len     = 8'd12;
        repeat (4) @(negedge userclk2);
        check("rst_txd", 64'(gmii_txd), 64'd0);
        check("rst_tx_en", 64'(gmii_tx_en), 64'd0);
        check("rst_tx_er", 64'(gmii_tx_er), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        sys_reset_n = 1'b1;
        @(negedge userclk2);

        run_frames(1, 11'd64, 8'd12, 64, 12, 19, 0);
        run_frames(2, 11'd46, 8'd12, 46, 12, 0, 0);
        run_frames(2, 11'd10, 8'd3, 46, 12, 0, 0);
        run_frames(1, 11'd2047, 8'd12, 1500, 12, 0, 0);

        frame_len = 11'd100;
        ifg_len   = 8'd12;
        e.len   = 100;
        e.seq   = m_seq;
        e.gap   = -1;
        e.trunc = 1'b1;
        exp_q.push_back(e);
        enable  = 1'b1;
        link_up = 1'b1;
        wait_txen(1'b1, 50, "rst_frame_start");
        repeat (30) @(negedge userclk2);
        sys_reset_n = 1'b0;
        enable      = 1'b0;
        @(negedge userclk2);
        check("midrst_tx_en", 64'(gmii_tx_en), 64'd0);
        check("midrst_txd", 64'(gmii_txd), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        m_seq = 8'h00;
        m_cnt = 32'h0;
        sys_reset_n = 1'b1;
        @(negedge userclk2);
        run_frames(1, 11'd64, 8'd20, 64, 20, 0, 0);

        run_frames(300, 11'd46, 8'd12, 46, 12, 0, 1000);

        repeat (20) @(negedge userclk2);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #720000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
